// File: rtl/riscv_pkg.sv
// Shared encodings for the pipeline: result-select codes, load/store funct3 codes
// and the memory-stage FSM state type.
package riscv_pkg;

  localparam logic [1:0] RES_SRC_ALU = 2'b00;
  localparam logic [1:0] RES_SRC_MEM = 2'b01;
  localparam logic [1:0] RES_SRC_PC4 = 2'b10;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    MEM_IDLE,
    MEM_WAIT_R
  } mem_state_e;

endpackage

// File: rtl/load_store_align.sv
// Combinational lane logic for the data-memory port: byte enables, store-data
// replication, load extraction/extension and misalignment detection.
module load_store_align
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [2:0]            funct3,
  input  logic [1:0]            addr_lo,
  input  logic [DATA_WIDTH-1:0] store_data,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic [3:0]            be,
  output logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] load_data,
  output logic                  misaligned
);

  logic [DATA_WIDTH-1:0] shifted;

  // funct3[1:0] carries the access size for both loads and stores
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = 1'b0;
    case (funct3[1:0])
      2'b00: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        be         = 4'b0011 << addr_lo;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: begin
        be         = 4'b1111;
        wdata      = store_data;
        misaligned = |addr_lo;
      end
    endcase
  end

  assign shifted = rdata >> {addr_lo, 3'b000};

  always_comb begin
    load_data = rdata;
    case (funct3)
      F3_LB:   load_data = {{(DATA_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_LH:   load_data = {{(DATA_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_LBU:  load_data = {{(DATA_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_LHU:  load_data = {{(DATA_WIDTH-16){1'b0}}, shifted[15:0]};
      default: load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// Memory/writeback stage: M-slot register, req/gnt/rvalid data-memory FSM,
// writeback result select and W register.
//   state      | meaning
//   MEM_IDLE   | no access pending; requests aligned mem ops until granted
//   MEM_WAIT_R | load granted, waiting for read data
module mem_wb_stage
  import riscv_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     reg_write_e,
  input  logic                     mem_write_e,
  input  logic [1:0]               res_src_e,
  input  logic [2:0]               funct3_e,
  input  logic [DATA_WIDTH-1:0]    alu_result_e,
  input  logic [DATA_WIDTH-1:0]    write_data_e,
  input  logic [4:0]               rd_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_e,
  output logic                     stall_m,
  output logic                     dmem_req,
  output logic                     dmem_we,
  output logic [ADDRESS_WIDTH-1:0] dmem_addr,
  output logic [DATA_WIDTH-1:0]    dmem_wdata,
  output logic [3:0]               dmem_be,
  input  logic                     dmem_gnt,
  input  logic                     dmem_rvalid,
  input  logic [DATA_WIDTH-1:0]    dmem_rdata,
  output logic [DATA_WIDTH-1:0]    alu_result_m,
  output logic [4:0]               rd_m,
  output logic                     reg_write_m,
  output logic [DATA_WIDTH-1:0]    result_w,
  output logic [4:0]               rd_w,
  output logic                     reg_write_w,
  output logic                     misalign_m
);

  logic                     mem_write_m;
  logic [1:0]               res_src_m;
  logic [2:0]               funct3_m;
  logic [DATA_WIDTH-1:0]    write_data_m;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_m;

  mem_state_e            state, state_next;
  logic                  load_m, store_m, mem_op, misaligned, retire, req;
  logic [3:0]            be;
  logic [DATA_WIDTH-1:0] wdata, load_data, wb_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_m  <= 1'b0;
      mem_write_m  <= 1'b0;
      res_src_m    <= RES_SRC_ALU;
      funct3_m     <= 3'b000;
      alu_result_m <= '0;
      write_data_m <= '0;
      rd_m         <= 5'd0;
      pc_plus4_m   <= '0;
    end else if (!stall_m) begin
      reg_write_m  <= reg_write_e;
      mem_write_m  <= mem_write_e;
      res_src_m    <= res_src_e;
      funct3_m     <= funct3_e;
      alu_result_m <= alu_result_e;
      write_data_m <= write_data_e;
      rd_m         <= rd_e;
      pc_plus4_m   <= pc_plus4_e;
    end
  end

  assign load_m  = (res_src_m == RES_SRC_MEM);
  assign store_m = mem_write_m;
  assign mem_op  = load_m | store_m;

  load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
    .funct3     (funct3_m),
    .addr_lo    (alu_result_m[1:0]),
    .store_data (write_data_m),
    .rdata      (dmem_rdata),
    .be         (be),
    .wdata      (wdata),
    .load_data  (load_data),
    .misaligned (misaligned)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= MEM_IDLE;
    else     state <= state_next;
  end

  // rvalid outside MEM_WAIT_R is deliberately ignored
  always_comb begin
    state_next = state;
    req        = 1'b0;
    retire     = 1'b0;
    case (state)
      MEM_IDLE: begin
        if (!mem_op || misaligned) begin
          retire = 1'b1;
        end else begin
          req = 1'b1;
          if (dmem_gnt) begin
            if (store_m) retire = 1'b1;
            else         state_next = MEM_WAIT_R;
          end
        end
      end
      MEM_WAIT_R: begin
        if (dmem_rvalid) begin
          retire     = 1'b1;
          state_next = MEM_IDLE;
        end
      end
      default: state_next = MEM_IDLE;
    endcase
  end

  assign stall_m    = mem_op & ~misaligned & ~retire;
  assign misalign_m = mem_op & misaligned & (state == MEM_IDLE);

  assign dmem_req   = req;
  assign dmem_we    = req & store_m;
  assign dmem_addr  = req ? ADDRESS_WIDTH'({alu_result_m[DATA_WIDTH-1:2], 2'b00}) : '0;
  assign dmem_be    = req ? be : 4'b0000;
  assign dmem_wdata = (req && store_m) ? wdata : '0;

  // a faulting load has no data; it records its address instead
  always_comb begin
    wb_value = alu_result_m;
    case (res_src_m)
      RES_SRC_PC4: wb_value = DATA_WIDTH'(pc_plus4_m);
      RES_SRC_MEM: wb_value = misaligned ? alu_result_m : load_data;
      default:     wb_value = alu_result_m;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_w <= 1'b0;
      rd_w        <= 5'd0;
      result_w    <= '0;
    end else if (retire) begin
      reg_write_w <= reg_write_m & ~misalign_m;
      rd_w        <= rd_m;
      result_w    <= wb_value;
    end else begin
      reg_write_w <= 1'b0;
    end
  end

endmodule
